reg_snapshot_buf: RTL

Register snapshot buffer between the SchoolMIPS register-file debug read port and the VGA debug screen. Once per video frame, at the start of the vertical sync pulse, it scans all CPU registers into a shadow buffer. The debug screen then reads this buffer combinationally through its `regAddr`/`regData` pair. Every displayed frame therefore shows one coherent register set, with no mid-frame tearing while the CPU runs.

---
 rtl/reg_snapshot_buf.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/reg_snapshot_buf.sv
// reg_snapshot_buf: once-per-frame snapshot of the CPU register file for the VGA debug screen.
// Build option REG_SNAPSHOT_DBLBUF_EN selects a double-buffered, tear-free bank; the default is a single bank.
module reg_snapshot_buf #(
   parameter int NREG = 32,
   parameter int AW   = 5,
   parameter int DW   = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          vsync,
   input  logic          freeze,
   output logic [AW-1:0] cpuRegAddr,
   input  logic [DW-1:0] cpuRegData,
   input  logic [AW-1:0] regAddr,
   output logic [DW-1:0] regData,
   output logic          busy,
   output logic [7:0]    frameCnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      LAST = 2'd2
   } state_t;

   localparam logic [AW-1:0] LastAddr = AW'(NREG - 1);

   state_t        r_state;
   state_t        w_stateNext;
   logic [AW-1:0] r_idx;
   logic [AW-1:0] w_idxNext;
   logic          r_vsyncQ;
   logic [AW-1:0] r_addrQ;
   logic          r_wrValid;
   logic [7:0]    r_frameCnt;
   logic          w_start;
   logic          w_commit;

   // Falling vsync edge only matters in IDLE; edges during a scan are dropped, not queued.
   assign w_start = r_vsyncQ && !vsync && !freeze;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_idx   <= '0;
      end else begin
         r_state <= w_stateNext;
         r_idx   <= w_idxNext;
      end
   end

   always_comb begin
      w_stateNext = r_state;
      w_idxNext   = r_idx;
      w_commit    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_start) begin
               w_stateNext = SCAN;
               w_idxNext   = '0;
            end
         end
         SCAN: begin
            if (r_idx == LastAddr) begin
               w_stateNext = LAST;
            end else begin
               w_idxNext = r_idx + AW'(1);
            end
         end
         LAST: begin
            w_stateNext = IDLE;
            w_commit    = 1'b1;
         end
         default: begin
            w_stateNext = IDLE;
         end
      endcase
   end

   // Read data arrives one cycle after its address, so the address and a write flag ride along.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_vsyncQ   <= 1'b1;
         r_addrQ    <= '0;
         r_wrValid  <= 1'b0;
         r_frameCnt <= '0;
      end else begin
         r_vsyncQ  <= vsync;
         r_addrQ   <= cpuRegAddr;
         r_wrValid <= (r_state == SCAN);
         if (w_commit) begin
            r_frameCnt <= r_frameCnt + 8'd1;
         end
      end
   end

   assign cpuRegAddr = (r_state == SCAN) ? r_idx : '0;
   assign busy       = (r_state != IDLE);
   assign frameCnt   = r_frameCnt;

`ifdef REG_SNAPSHOT_DBLBUF_EN
   logic          r_sel;
   logic [DW-1:0] r_bank [2][NREG];

   // Capture fills the back bank; the swap at commit flips every entry in the same cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sel <= 1'b0;
         for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < NREG; i++) begin
               r_bank[b][i] <= '0;
            end
         end
      end else begin
         if (r_wrValid) begin
            r_bank[~r_sel][r_addrQ] <= cpuRegData;
         end
         if (w_commit) begin
            r_sel <= ~r_sel;
         end
      end
   end

   assign regData = r_bank[r_sel][regAddr];
`else
   logic [DW-1:0] r_bank [NREG];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) begin
            r_bank[i] <= '0;
         end
      end else if (r_wrValid) begin
         r_bank[r_addrQ] <= cpuRegData;
      end
   end

   assign regData = r_bank[regAddr];
`endif

endmodule
